// File: rtl/uart_rx_if.sv
// uart_rx_if -- bundles the serial line, the consumer handshake and the
// receiver status outputs of uart_rx.
//   rx        : serial line, idle high (driven by master)
//   rd_en     : consumer acknowledge of the held byte (driven by master)
//   data_out  : last received byte (driven by slave)
//   valid_out : data_out holds an unread byte
//   frame_err : one-cycle pulse on a bad stop bit
//   overrun   : sticky, an unread byte was overwritten
//   busy      : receiver is inside a frame
// The receiver itself connects through the slave modport.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 rd_en;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid_out;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx, rd_en,
    input  data_out, valid_out, frame_err, overrun, busy
  );

  modport slave (
    input  rx, rd_en,
    output data_out, valid_out, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver with a single-byte holding register.
//   clk_in : clock at OVERSAMPLING x baud rate
//   n_rst  : asynchronous active-low reset
//   bus    : uart_rx_if slave (rx, rd_en in; data_out, valid_out, frame_err,
//            overrun, busy out)
// The line is synchronized, the falling edge of the start bit is confirmed at
// mid-bit, and every later bit is sampled one full bit period apart so all
// samples land at mid-bit. A good frame loads the holding register on the cycle
// after the last stop sample; the receiver never waits on the consumer.
module uart_rx #(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int OVERSAMPLING = 16
) (
  input logic     clk_in,
  input logic     n_rst,
  uart_rx_if.slave bus
);

  localparam int CNT_W   = $clog2(OVERSAMPLING);
  localparam int BIT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BIT_W   = $clog2(BIT_MAX + 1);

  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(OVERSAMPLING / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(OVERSAMPLING - 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e               state_q;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [CNT_W-1:0]     clk_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 stop_err_q;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_err_q, frame_err_d;

  logic                 frame_done;
  logic                 frame_ok;

  // Two-flop synchronizer; resets to the idle line level so reset release
  // never looks like a start bit.
  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= 2'b11;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      sync_q <= {sync_q[0], bus.rx};
    end
  end

  assign rx_s = sync_q[1];

  // Frame FSM. clk_cnt measures time inside a bit; bit_cnt counts data bits
  // in DATA and stop bits in STOP.
  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      // NOTE: the shift register is datapath, yet it is reset as well so the
      // whole block has a defined state the moment n_rst is released.
      shift_q    <= '0;
      stop_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            clk_cnt_q <= '0;
            state_q   <= START;
          end
        end

        START: begin
          if (clk_cnt_q == HALF_CNT) begin
            // Still low at mid start bit: a real frame. High: a glitch,
            // dropped silently.
            if (!rx_s) begin
              clk_cnt_q <= '0;
              bit_cnt_q <= '0;
              state_q   <= DATA;
            end else begin
              state_q   <= IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (clk_cnt_q == LAST_CNT) begin
            // LSB arrives first, so shifting right leaves it at bit 0.
            shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
            clk_cnt_q <= '0;
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q  <= '0;
              stop_err_q <= 1'b0;
              state_q    <= STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end

        STOP: begin
          if (clk_cnt_q == LAST_CNT) begin
            clk_cnt_q  <= '0;
            stop_err_q <= stop_err_q | ~rx_s;
            if (bit_cnt_q == LAST_STOP) begin
              // Straight back to IDLE half a bit early so a start bit that
              // follows immediately is still caught on its falling edge.
              bit_cnt_q <= '0;
              state_q   <= IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // The final stop sample is taken this cycle; earlier stop samples are
  // folded into stop_err_q.
  assign frame_done = (state_q == STOP) && (clk_cnt_q == LAST_CNT) &&
                      (bit_cnt_q == LAST_STOP);
  assign frame_ok   = frame_done && rx_s && !stop_err_q;

  // Holding register. A consume and a load in the same cycle count the old
  // byte as read, so overrun only rises when an unread byte is lost.
  always_comb begin
    // NOTE: every _d signal gets a default first, so no path through this
    // block leaves it unassigned and no latch is inferred.
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_done && !frame_ok;

    if (bus.rd_en && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    if (frame_ok) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !bus.rd_en) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
